// File: rtl/dmem_ctrl_pkg.sv
// Shared widths, response codes and FSM state encoding for the data-memory controller.
package dmem_ctrl_pkg;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned MEM_CODE_W  = 2;
    localparam int unsigned MEM_COUNT_W = 3;

    typedef enum logic [MEM_CODE_W-1:0] {
        MEM_CODE_NONE     = 2'd0,
        MEM_CODE_OK       = 2'd1,
        MEM_CODE_MISALIGN = 2'd2,
        MEM_CODE_BUS_ERR  = 2'd3
    } mem_code_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP
    } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane helper: write strobes, store replication, misalign check
// on the request side and right-justified zero-extended extraction on the read side.
module dmem_lane_align
    import dmem_ctrl_pkg::*;
(
    input  logic [1:0]             req_lane_i,
    input  logic [MEM_COUNT_W-1:0] req_count_i,
    input  logic [WORD_W-1:0]      req_wdata_i,
    output logic [3:0]             wstrb_o,
    output logic [WORD_W-1:0]      wdata_o,
    output logic                   misalign_o,
    input  logic [1:0]             rsp_lane_i,
    input  logic [MEM_COUNT_W-1:0] rsp_count_i,
    input  logic [WORD_W-1:0]      rsp_rdata_i,
    output logic [WORD_W-1:0]      rd_data_o
);

    logic [WORD_W-1:0] shifted;

    // Any count other than 1/2/4 is reported through the misalign flag.
    always_comb begin
        wstrb_o    = '0;
        wdata_o    = req_wdata_i;
        misalign_o = 1'b1;
        case (req_count_i)
            3'd1: begin
                wstrb_o    = 4'b0001 << req_lane_i;
                wdata_o    = {4{req_wdata_i[7:0]}};
                misalign_o = 1'b0;
            end
            3'd2: begin
                wstrb_o    = 4'b0011 << req_lane_i;
                wdata_o    = {2{req_wdata_i[15:0]}};
                misalign_o = req_lane_i[0];
            end
            3'd4: begin
                wstrb_o    = 4'hF;
                misalign_o = (req_lane_i != 2'd0);
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted   = rsp_rdata_i >> {rsp_lane_i, 3'b000};
        rd_data_o = rsp_rdata_i;
        case (rsp_count_i)
            3'd1:    rd_data_o = {{(WORD_W-8){1'b0}}, shifted[7:0]};
            3'd2:    rd_data_o = {{(WORD_W-16){1'b0}}, shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: runs one EX-stage request as a single valid/ready bus
// transaction, stalls the pipeline while it is outstanding and returns a one-cycle response.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned TO_W           = 9
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic [ADDR_W-1:0]      i_req_addr,
    input  logic [WORD_W-1:0]      i_req_wr_data,
    input  logic                   i_req_wr_en,
    input  logic [MEM_COUNT_W-1:0] i_req_count,
    output logic [WORD_W-1:0]      o_res_rd_data,
    output logic [MEM_CODE_W-1:0]  o_res_code,
    output logic                   o_stall,
    output logic                   o_bus_valid,
    output logic [ADDR_W-1:0]      o_bus_addr,
    output logic                   o_bus_we,
    output logic [3:0]             o_bus_wstrb,
    output logic [WORD_W-1:0]      o_bus_wdata,
    input  logic                   i_bus_ready,
    input  logic [WORD_W-1:0]      i_bus_rdata,
    input  logic                   i_bus_err
);

    state_e                 state_q, state_d;
    mem_code_e              code_q, code_d;
    logic [WORD_W-1:0]      rd_q, rd_d;
    logic [TO_W-1:0]        to_q, to_d;
    logic [ADDR_W-1:0]      addr_q;
    logic                   we_q;
    logic [3:0]             wstrb_q;
    logic [WORD_W-1:0]      wdata_q;
    logic [1:0]             lane_q;
    logic [MEM_COUNT_W-1:0] count_q;

    logic              accept, load_req, timeout;
    logic [3:0]        al_wstrb;
    logic [WORD_W-1:0] al_wdata, al_rdata;
    logic              al_misalign;

    dmem_lane_align u_align (
        .req_lane_i  (i_req_addr[1:0]),
        .req_count_i (i_req_count),
        .req_wdata_i (i_req_wr_data),
        .wstrb_o     (al_wstrb),
        .wdata_o     (al_wdata),
        .misalign_o  (al_misalign),
        .rsp_lane_i  (lane_q),
        .rsp_count_i (count_q),
        .rsp_rdata_i (i_bus_rdata),
        .rd_data_o   (al_rdata)
    );

    assign accept   = (state_q != ST_REQ) && (i_req_count != '0);
    assign load_req = accept && !al_misalign;
    assign timeout  = (to_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            code_q  <= MEM_CODE_NONE;
            rd_q    <= '0;
            to_q    <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wstrb_q <= '0;
            wdata_q <= '0;
            lane_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            rd_q    <= rd_d;
            to_q    <= to_d;
            if (load_req) begin
                addr_q  <= {i_req_addr[ADDR_W-1:2], 2'b00};
                we_q    <= i_req_wr_en;
                wstrb_q <= i_req_wr_en ? al_wstrb : '0;
                wdata_q <= al_wdata;
                lane_q  <= i_req_addr[1:0];
                count_q <= i_req_count;
            end
        end
    end

    // code_q is only non-NONE in the single cycle spent in RESP.
    always_comb begin
        state_d = state_q;
        code_d  = MEM_CODE_NONE;
        rd_d    = rd_q;
        to_d    = '0;
        case (state_q)
            ST_REQ: begin
                if (i_bus_ready) begin
                    state_d = ST_RESP;
                    code_d  = i_bus_err ? MEM_CODE_BUS_ERR : MEM_CODE_OK;
                    rd_d    = (i_bus_err || we_q) ? '0 : al_rdata;
                end else if (timeout) begin
                    state_d = ST_RESP;
                    code_d  = MEM_CODE_BUS_ERR;
                    rd_d    = '0;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (al_misalign) begin
                        state_d = ST_RESP;
                        code_d  = MEM_CODE_MISALIGN;
                        rd_d    = '0;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
        endcase
    end

    always_comb begin
        o_bus_valid = (state_q == ST_REQ);
        o_stall     = (state_q == ST_REQ) || load_req;
        o_res_code  = code_q;
    end

    assign o_res_rd_data = rd_q;
    assign o_bus_addr    = addr_q;
    assign o_bus_we      = we_q;
    assign o_bus_wstrb   = wstrb_q;
    assign o_bus_wdata   = wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: directed requests push expected responses and bus
// fields into queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_dmem_ctrl;

    localparam logic [1:0] C_NONE = 2'd0;
    localparam logic [1:0] C_OK   = 2'd1;
    localparam logic [1:0] C_MIS  = 2'd2;
    localparam logic [1:0] C_BERR = 2'd3;

    typedef struct packed {
        logic [1:0]  code;
        logic [31:0] rd;
    } resp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } bus_t;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [31:0] req_addr, req_wr_data;
    logic        req_wr_en;
    logic [2:0]  req_count;
    logic [31:0] res_rd_data;
    logic [1:0]  res_code;
    logic        stall, bus_valid, bus_we, bus_ready, bus_err;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    resp_t resp_q[$];
    bus_t  bus_q[$];

    always #5 clk = ~clk;

    dmem_ctrl #(.TIMEOUT_CYCLES(4), .TO_W(3)) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .i_req_addr    (req_addr),
        .i_req_wr_data (req_wr_data),
        .i_req_wr_en   (req_wr_en),
        .i_req_count   (req_count),
        .o_res_rd_data (res_rd_data),
        .o_res_code    (res_code),
        .o_stall       (stall),
        .o_bus_valid   (bus_valid),
        .o_bus_addr    (bus_addr),
        .o_bus_we      (bus_we),
        .o_bus_wstrb   (bus_wstrb),
        .o_bus_wdata   (bus_wdata),
        .i_bus_ready   (bus_ready),
        .i_bus_rdata   (bus_rdata),
        .i_bus_err     (bus_err)
    );

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endfunction

    // Monitor: responses and bus fields compared against queued expectations.
    resp_t er;
    bus_t  eb;
    logic  vprev = 1'b0;
    logic  have_bus = 1'b0;
    always @(negedge clk) begin
        if (res_code !== C_NONE) begin
            if (resp_q.size() == 0) begin
                chk("unexpected_resp", {30'd0, res_code}, {30'd0, C_NONE});
            end else begin
                er = resp_q.pop_front();
                chk("res_code", {30'd0, res_code}, {30'd0, er.code});
                chk("res_rd_data", res_rd_data, er.rd);
            end
        end
        if (bus_valid && !vprev) begin
            if (bus_q.size() == 0) begin
                chk("unexpected_bus_valid", {31'd0, bus_valid}, 32'd0);
                have_bus = 1'b0;
            end else begin
                eb = bus_q.pop_front();
                have_bus = 1'b1;
            end
        end
        if (bus_valid && have_bus) begin
            chk("bus_addr", bus_addr, eb.addr);
            chk("bus_we", {31'd0, bus_we}, {31'd0, eb.we});
            chk("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, eb.wstrb});
            if (eb.we) chk("bus_wdata", bus_wdata, eb.wdata);
        end
        if (!bus_valid) have_bus = 1'b0;
        vprev = bus_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // nreq = REQ cycles expected; ready is raised in the last one when give_ready is set.
    task automatic txn(input logic [31:0] addr, input logic [31:0] wd, input logic we,
                       input logic [2:0] cnt, input bit legal, input int unsigned nreq,
                       input bit give_ready, input logic [31:0] rd, input logic err,
                       input logic [1:0] ecode, input logic [31:0] erd,
                       input logic [31:0] ebaddr, input logic [3:0] ewstrb,
                       input logic [31:0] ewdata, input bit b2b);
        int unsigned nv;
        int unsigned ns;
        resp_q.push_back('{code: ecode, rd: erd});
        if (legal) bus_q.push_back('{addr: ebaddr, we: we, wstrb: ewstrb, wdata: ewdata});
        req_addr    = addr;
        req_wr_data = wd;
        req_wr_en   = we;
        req_count   = cnt;
        @(negedge clk);
        ns = int'(stall);
        nv = int'(bus_valid);
        tick();
        if (legal) begin
            req_addr    = 32'hFFFF_FFFF;
            req_wr_data = 32'h5A5A_5A5A;
            req_count   = 3'd4;
            for (int unsigned k = 1; k <= nreq; k++) begin
                if (give_ready && k == nreq) begin
                    bus_ready = 1'b1;
                    bus_rdata = rd;
                    bus_err   = err;
                end
                @(negedge clk);
                ns += int'(stall);
                nv += int'(bus_valid);
                tick();
                bus_ready = 1'b0;
                bus_err   = 1'b0;
            end
        end
        req_count = 3'd0;
        chk("stall_cycles", ns, legal ? nreq + 1 : 0);
        chk("valid_cycles", nv, legal ? nreq : 0);
        if (!b2b) begin
            @(negedge clk);
            chk("resp_stall", {31'd0, stall}, 32'd0);
            chk("resp_valid", {31'd0, bus_valid}, 32'd0);
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn     = 1'b0;
        req_addr    = '0;
        req_wr_data = '0;
        req_wr_en   = 1'b0;
        req_count   = '0;
        bus_ready   = 1'b0;
        bus_rdata   = '0;
        bus_err     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'd0, bus_valid}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_code", {30'd0, res_code}, {30'd0, C_NONE});
        chk("rst_rd_data", res_rd_data, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wstrb", {28'd0, bus_wstrb}, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
        aresetn = 1'b1;
        tick();
        tick();

        // load word, ready in third REQ cycle
        txn(32'h100, 32'h0, 1'b0, 3'd4, 1, 3, 1, 32'hDEAD_BEEF, 1'b0, C_OK, 32'hDEAD_BEEF, 32'h100, 4'h0, 32'h0, 0);
        // stores: byte, half, word
        txn(32'h203, 32'h0000_00A5, 1'b1, 3'd1, 1, 1, 1, 32'h1122_3344, 1'b0, C_OK, 32'h0, 32'h200, 4'b1000, 32'hA5A5_A5A5, 0);
        txn(32'h206, 32'h0000_BEEF, 1'b1, 3'd2, 1, 2, 1, 32'h5555_5555, 1'b0, C_OK, 32'h0, 32'h204, 4'b1100, 32'hBEEF_BEEF, 0);
        txn(32'h308, 32'hCAFE_F00D, 1'b1, 3'd4, 1, 1, 1, 32'h0, 1'b0, C_OK, 32'h0, 32'h308, 4'hF, 32'hCAFE_F00D, 0);
        // load half upper lane, then misaligned / illegal requests
        txn(32'h102, 32'h0, 1'b0, 3'd2, 1, 2, 1, 32'h1234_ABCD, 1'b0, C_OK, 32'h0000_1234, 32'h100, 4'h0, 32'h0, 0);
        txn(32'h101, 32'h0, 1'b0, 3'd2, 0, 0, 0, 32'h0, 1'b0, C_MIS, 32'h0, 32'h0, 4'h0, 32'h0, 0);
        txn(32'h200, 32'h0, 1'b0, 3'd3, 0, 0, 0, 32'h0, 1'b0, C_MIS, 32'h0, 32'h0, 4'h0, 32'h0, 0);
        txn(32'h302, 32'h1234_5678, 1'b1, 3'd4, 0, 0, 0, 32'h0, 1'b0, C_MIS, 32'h0, 32'h0, 4'h0, 32'h0, 0);
        // load byte lane 1
        txn(32'h101, 32'h0, 1'b0, 3'd1, 1, 1, 1, 32'h1122_3344, 1'b0, C_OK, 32'h0000_0033, 32'h100, 4'h0, 32'h0, 0);
        // bus error, then a request issued in the RESP cycle
        txn(32'h500, 32'h0, 1'b0, 3'd4, 1, 1, 1, 32'hFFFF_FFFF, 1'b1, C_BERR, 32'h0, 32'h500, 4'h0, 32'h0, 1);
        txn(32'h503, 32'h0, 1'b0, 3'd1, 1, 2, 1, 32'hAB00_0000, 1'b0, C_OK, 32'h0000_00AB, 32'h500, 4'h0, 32'h0, 0);
        // timeout with no ready, then a late ready that must be ignored
        txn(32'h400, 32'h0, 1'b0, 3'd4, 1, 4, 0, 32'h0, 1'b0, C_BERR, 32'h0, 32'h400, 4'h0, 32'h0, 0);
        bus_ready = 1'b1;
        bus_rdata = 32'h7777_7777;
        repeat (2) begin
            @(negedge clk);
            chk("late_ready_valid", {31'd0, bus_valid}, 32'd0);
            chk("late_ready_stall", {31'd0, stall}, 32'd0);
            tick();
        end
        bus_ready = 1'b0;

        // async reset while a transaction is outstanding
        req_addr  = 32'h600;
        req_wr_en = 1'b0;
        req_count = 3'd4;
        tick();
        req_count = 3'd0;
        #2;
        chk("pre_rst_valid", {31'd0, bus_valid}, 32'd1);
        chk("pre_rst_addr", bus_addr, 32'h600);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, bus_valid}, 32'd0);
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        chk("mid_rst_code", {30'd0, res_code}, {30'd0, C_NONE});
        chk("mid_rst_addr", bus_addr, 32'd0);
        @(negedge clk);
        aresetn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_valid", {31'd0, bus_valid}, 32'd0);
            chk("post_rst_stall", {31'd0, stall}, 32'd0);
        end

        chk("resp_q_drained", resp_q.size(), 32'd0);
        chk("bus_q_drained", bus_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
